mybus_seq_ctrl: RTL and testbench
=================================

MYBUS_SEQ_CTRL -- requirements
Module: mybus_seq_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_W, 8, word width per channel; legal range 1..32.
- NUM_CH, 2, number of receive channels; legal range 1..8.
- CH_W, max(1,$clog2(NUM_CH)), width of tx_ch; derived, not overridden.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on the rising edge.
- rst, in, 1, synchronous active-high reset.
- start, in, NUM_CH, per-channel request to begin a word.
- data, in, NUM_CH, per-channel serial data; LSB first.
- ready, out, NUM_CH, channel idle and able to accept start.
- dataReady, out, NUM_CH, channel holds a complete word awaiting transmit.
- execute, out, 1, one-cycle pulse marking the start of a transmit.
- dataTx, out, 1, serial transmit data; LSB first.
- tx_valid, out, 1, dataTx carries a valid bit.
- tx_ch, out, CH_W, index of the channel being transmitted.
- err_overrun, out, NUM_CH, sticky flag: start asserted while the channel was not idle.

REQ-003 Clock is clk; reset is rst, synchronous, active-high; there SHALL be no other clock or reset.

REQ-004 All outputs SHALL be driven directly from flops.

Function
REQ-005 Each channel SHALL run an independent FSM with states IDLE, RX and HOLD; ready=1 only in IDLE, dataReady=1 only in HOLD.

REQ-006 IDLE->RX SHALL occur when start[i]=1; the data bit in the start cycle SHALL NOT be sampled.

REQ-007 In RX the channel SHALL sample data[i] on each of the next DATA_W cycles into bit 0..DATA_W-1, tracked by a counter, then go to HOLD.

REQ-008 HOLD->IDLE SHALL occur on the edge at which the channel is granted; the word is then copied to the transmit shift register.

REQ-009 If start[i]=1 while channel i is in RX or HOLD, the start SHALL be ignored, err_overrun[i] SHALL be set and held until rst, and the FSM SHALL be unaffected.

REQ-010 The transmitter FSM SHALL have states TX_IDLE, TX_EXEC and TX_SHIFT.

REQ-011 In TX_IDLE with any dataReady=1, the transmitter SHALL grant one channel by round-robin: lowest index strictly after the last granted channel, wrapping; after reset, channel 0 has highest priority.

REQ-012 On grant the transmitter SHALL load the word, set tx_ch and enter TX_EXEC, in which execute=1 for exactly one cycle.

REQ-013 TX_SHIFT SHALL last DATA_W cycles, with tx_valid=1 and dataTx = word bit k in the k-th cycle; it then returns to TX_IDLE.

REQ-014 The transmitter SHALL spend at least one cycle in TX_IDLE between transfers; no grant may occur while in TX_EXEC or TX_SHIFT.

REQ-015 Latency SHALL be as follows for start at cycle t with the transmitter idle:
- bits sampled at t+1..t+DATA_W;
- dataReady=1 at t+DATA_W+1;
- execute=1 and ready=1 at t+DATA_W+2;
- dataTx bits at t+DATA_W+3..t+2*DATA_W+2.

REQ-016 A channel granted and restarted SHALL accept a new start in its first IDLE cycle, concurrently with its prior word transmitting.

REQ-017 Simultaneous start on several channels SHALL be accepted independently; simultaneous dataReady SHALL be resolved only by REQ-011.

REQ-018 When tx_valid=0, dataTx SHALL be 0; tx_ch SHALL hold its last value.

Reset
REQ-019 While rst=1 the block SHALL be in the following state:
- all channels IDLE, so ready=all ones;
- dataReady=0, execute=0, dataTx=0, tx_valid=0, tx_ch=0, err_overrun=0;
- counters and shift registers cleared;
- round-robin pointer set so that channel 0 wins next.

REQ-020 rst asserted mid-RX or mid-TX_SHIFT SHALL abort the operation with no further execute or tx_valid; the partial word is discarded.

Verification (DATA_W=8, NUM_CH=2)
REQ-021 The bench SHALL cover the following directed scenarios:
- Single word: start[0] at cycle 10 with data 8'hA5 LSB-first at cycles 11-18 -> dataReady[0] at 19; execute and ready[0] at 20; tx_ch=0; dataTx 1,0,1,0,0,1,0,1 at 21-28.
- Contention: both channels start at cycle 10 with 8'h3C and 8'hC3 -> ch0 transmitted first at 21-28; ch1 execute at 30 with tx_ch=1; bits at 31-38.
- Round-robin: after ch0 is granted, both channels are in HOLD -> ch1 is granted next; then ch0 after that.
- Overrun: start[1] in the 4th RX cycle -> err_overrun[1]=1 and stays set; the word is still received intact and transmitted.
- Reset mid-transfer: rst at the 3rd TX_SHIFT cycle -> next cycle tx_valid=0, dataTx=0, ready=2'b11, no execute afterwards.
- Back-to-back: start[0] again at the ready[0] cycle while the prior word shifts -> second word gets execute at the first cycle after TX_IDLE.

Source files
------------

// File: rtl/mybus_seq_ctrl_if.sv
// rtl/mybus_seq_ctrl_if.sv - request/transmit signal bundle for mybus_seq_ctrl
interface mybus_seq_ctrl_if #(
   parameter int NUM_CH = 2
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0] start;
   logic [NUM_CH-1:0] data;
   logic [NUM_CH-1:0] ready;
   logic [NUM_CH-1:0] dataReady;
   logic              execute;
   logic              dataTx;
   logic              tx_valid;
   logic [CH_W-1:0]   tx_ch;
   logic [NUM_CH-1:0] err_overrun;

   modport master (
      output start, data,
      input  ready, dataReady, execute, dataTx, tx_valid, tx_ch, err_overrun
   );

   modport slave (
      input  start, data,
      output ready, dataReady, execute, dataTx, tx_valid, tx_ch, err_overrun
   );
endinterface

// File: rtl/mybus_seq_ctrl.sv
// rtl/mybus_seq_ctrl.sv - per-channel serial word receivers feeding one round-robin serial transmitter
module mybus_seq_ctrl #(
   parameter int DATA_W = 8,
   parameter int NUM_CH = 2
) (
   input  logic             clk,
   input  logic             rst,
   mybus_seq_ctrl_if.slave  bus
);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, RX, HOLD} ch_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_EXEC, TX_SHIFT} tx_state_t;

   ch_state_t         ch_state [NUM_CH];
   ch_state_t         ch_next  [NUM_CH];
   logic [CNT_W-1:0]  ch_cnt   [NUM_CH];
   logic [DATA_W-1:0] ch_word  [NUM_CH];

   logic [NUM_CH-1:0] ready_q, ready_d;
   logic [NUM_CH-1:0] drdy_q, drdy_d;
   logic [NUM_CH-1:0] err_q, err_d;

   tx_state_t         tx_state, tx_next;
   logic [CNT_W-1:0]  tx_cnt;
   logic [DATA_W-1:0] tx_sreg;
   logic [CH_W-1:0]   tx_ch_q;
   logic [CH_W-1:0]   last_grant;
   logic [CH_W-1:0]   grant_ch;
   logic              grant_valid;
   logic              grant_fire;
   logic              exec_q, exec_d;
   logic              txv_q, txv_d;
   logic              dtx_q, dtx_d;

   // Round-robin search starts just after the last granted channel and wraps.
   always_comb begin
      grant_valid = 1'b0;
      grant_ch    = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         if (!grant_valid && drdy_q[CH_W'((int'(last_grant) + k) % NUM_CH)]) begin
            grant_valid = 1'b1;
            grant_ch    = CH_W'((int'(last_grant) + k) % NUM_CH);
         end
      end
   end

   assign grant_fire = (tx_state == TX_IDLE) && grant_valid;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         ch_next[i] = ch_state[i];
         case (ch_state[i])
            IDLE:    if (bus.start[i]) ch_next[i] = RX;
            RX:      if (ch_cnt[i] == CNT_LAST) ch_next[i] = HOLD;
            HOLD:    if (grant_fire && (grant_ch == CH_W'(i))) ch_next[i] = IDLE;
            default: ch_next[i] = IDLE;
         endcase
      end
   end

   // Channel flags are registered from the next state so they come straight off flops.
   always_comb begin
      ready_d = '0;
      drdy_d  = '0;
      err_d   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ready_d[i] = (ch_next[i] == IDLE);
         drdy_d[i]  = (ch_next[i] == HOLD);
         err_d[i]   = err_q[i] | (bus.start[i] & (ch_state[i] != IDLE));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            ch_state[i] <= IDLE;
            ch_cnt[i]   <= '0;
            ch_word[i]  <= '0;
         end
         ready_q <= '1;
         drdy_q  <= '0;
         err_q   <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            ch_state[i] <= ch_next[i];
            if (ch_state[i] == IDLE) begin
               ch_cnt[i] <= '0;
            end else if (ch_state[i] == RX) begin
               ch_word[i][ch_cnt[i]] <= bus.data[i];
               ch_cnt[i]             <= ch_cnt[i] + CNT_W'(1);
            end
         end
         ready_q <= ready_d;
         drdy_q  <= drdy_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         TX_IDLE:  if (grant_valid) tx_next = TX_EXEC;
         TX_EXEC:  tx_next = TX_SHIFT;
         TX_SHIFT: if (tx_cnt == CNT_LAST) tx_next = TX_IDLE;
         default:  tx_next = TX_IDLE;
      endcase
   end

   // The shift register's LSB is presented on every cycle that will be a shift cycle.
   always_comb begin
      exec_d = (tx_next == TX_EXEC);
      txv_d  = (tx_next == TX_SHIFT);
      dtx_d  = txv_d ? tx_sreg[0] : 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state   <= TX_IDLE;
         tx_cnt     <= '0;
         tx_sreg    <= '0;
         tx_ch_q    <= '0;
         last_grant <= CH_W'(NUM_CH - 1);
         exec_q     <= 1'b0;
         txv_q      <= 1'b0;
         dtx_q      <= 1'b0;
      end else begin
         tx_state <= tx_next;
         if (grant_fire) begin
            tx_sreg    <= ch_word[grant_ch];
            tx_ch_q    <= grant_ch;
            last_grant <= grant_ch;
         end else if (txv_d) begin
            tx_sreg <= tx_sreg >> 1;
         end
         if (tx_state == TX_SHIFT) begin
            tx_cnt <= tx_cnt + CNT_W'(1);
         end else begin
            tx_cnt <= '0;
         end
         exec_q <= exec_d;
         txv_q  <= txv_d;
         dtx_q  <= dtx_d;
      end
   end

   assign bus.ready       = ready_q;
   assign bus.dataReady   = drdy_q;
   assign bus.err_overrun = err_q;
   assign bus.execute     = exec_q;
   assign bus.tx_valid    = txv_q;
   assign bus.dataTx      = dtx_q;
   assign bus.tx_ch       = tx_ch_q;
endmodule

// File: tb/tb_mybus_seq_ctrl.sv
// tb/tb_mybus_seq_ctrl.sv - directed and randomized self-checking bench for mybus_seq_ctrl
module tb_mybus_seq_ctrl;
   localparam int DW = 8;
   localparam int NC = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mybus_seq_ctrl_if #(.NUM_CH(NC)) bus ();

   mybus_seq_ctrl #(.DATA_W(DW), .NUM_CH(NC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;
   bit chk_en  = 0;

   task automatic check(string name, int act, int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic int bitof(logic [7:0] w, int k);
      logic [7:0] t;
      t = w >> k;
      return int'(t[0]);
   endfunction

   // Reference model: channel mode 0=idle 1=receiving 2=holding; the transmitter is a
   // queue of per-cycle output slots filled whenever a word is granted.
   int   m_mode [NC];
   bit   m_bits [NC][$];
   bit   pl_ex[$], pl_v[$], pl_b[$];
   int   m_last;
   bit   m_idle;
   logic [NC-1:0] e_ready, e_dr, e_err;
   bit   e_ex, e_v, e_b;
   int   e_ch;

   always @(posedge clk) begin : model
      int g;
      cyc++;
      if (rst) begin
         for (int i = 0; i < NC; i++) begin
            m_mode[i] = 0;
            m_bits[i].delete();
         end
         pl_ex.delete(); pl_v.delete(); pl_b.delete();
         m_last = NC - 1; m_idle = 1;
         e_err = '0; e_ch = 0; e_ex = 0; e_v = 0; e_b = 0;
      end else begin
         g = -1;
         if (m_idle) begin
            for (int k = 1; k <= NC; k++)
               if (g < 0 && m_mode[(m_last + k) % NC] == 2) g = (m_last + k) % NC;
         end
         if (g >= 0) begin
            pl_ex.push_back(1); pl_v.push_back(0); pl_b.push_back(0);
            for (int k = 0; k < DW; k++) begin
               pl_ex.push_back(0); pl_v.push_back(1); pl_b.push_back(m_bits[g][k]);
            end
            m_last = g;
            e_ch   = g;
         end
         for (int i = 0; i < NC; i++) begin
            if (bus.start[i] && m_mode[i] != 0) e_err[i] = 1'b1;
            if (m_mode[i] == 0) begin
               if (bus.start[i]) begin
                  m_mode[i] = 1;
                  m_bits[i].delete();
               end
            end else if (m_mode[i] == 1) begin
               m_bits[i].push_back(bus.data[i]);
               if (m_bits[i].size() == DW) m_mode[i] = 2;
            end else if (g == i) begin
               m_mode[i] = 0;
            end
         end
         if (pl_ex.size() > 0) begin
            e_ex = pl_ex.pop_front(); e_v = pl_v.pop_front(); e_b = pl_b.pop_front();
            m_idle = 0;
         end else begin
            e_ex = 0; e_v = 0; e_b = 0;
            m_idle = 1;
         end
      end
      for (int i = 0; i < NC; i++) begin
         e_ready[i] = (m_mode[i] == 0);
         e_dr[i]    = (m_mode[i] == 2);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("ready",       int'(bus.ready),       int'(e_ready));
         check("dataReady",   int'(bus.dataReady),   int'(e_dr));
         check("err_overrun", int'(bus.err_overrun), int'(e_err));
         check("execute",     int'(bus.execute),     int'(e_ex));
         check("tx_valid",    int'(bus.tx_valid),    int'(e_v));
         check("dataTx",      int'(bus.dataTx),      int'(e_b));
         check("tx_ch",       int'(bus.tx_ch),       e_ch);
      end
   end

   task automatic put_word(int ch, int st, logic [7:0] w, int n);
      if (n == st) bus.start = bus.start | (NC'(1) << ch);
      if (n > st && n <= st + DW && bitof(w, n - st - 1) == 1)
         bus.data = bus.data | (NC'(1) << ch);
   endtask

   task automatic drive(int sid, int n);
      bus.start = '0;
      bus.data  = '0;
      rst       = 1'b0;
      case (sid)
         0: put_word(0, 10, 8'hA5, n);
         1: begin
            put_word(0, 10, 8'h3C, n);
            put_word(1, 10, 8'hC3, n);
            put_word(0, 20, 8'h5A, n);
         end
         2: begin
            put_word(1, 10, 8'h96, n);
            if (n == 14) bus.start = bus.start | 2'b10;
         end
         3: begin
            put_word(0, 10, 8'hA5, n);
            rst = (n == 23);
         end
         default: begin
            put_word(0, 10, 8'hA5, n);
            put_word(0, 20, 8'h69, n);
         end
      endcase
   endtask

   task automatic lit_word(string name, logic [7:0] w, int first, int n);
      if (n >= first && n < first + DW) begin
         check({name, "_valid"}, int'(bus.tx_valid), 1);
         check({name, "_bit"},   int'(bus.dataTx),   bitof(w, n - first));
      end
   endtask

   task automatic lit(int sid, int n);
      if (n == 0) begin
         check("rst_ready", int'(bus.ready),       3);
         check("rst_dr",    int'(bus.dataReady),   0);
         check("rst_err",   int'(bus.err_overrun), 0);
         check("rst_txv",   int'(bus.tx_valid),    0);
         check("rst_exec",  int'(bus.execute),     0);
         check("rst_txch",  int'(bus.tx_ch),       0);
      end
      case (sid)
         0: begin
            if (n == 19) check("s0_dr", int'(bus.dataReady), 1);
            if (n == 20) begin
               check("s0_exec",  int'(bus.execute),  1);
               check("s0_ready", int'(bus.ready[0]), 1);
               check("s0_txch",  int'(bus.tx_ch),    0);
            end
            lit_word("s0", 8'hA5, 21, n);
            if (n == 29) check("s0_txv_end", int'(bus.tx_valid), 0);
         end
         1: begin
            if (n == 20) begin
               check("s1_exec0", int'(bus.execute),   1);
               check("s1_txch0", int'(bus.tx_ch),     0);
               check("s1_dr20",  int'(bus.dataReady), 2);
            end
            lit_word("s1_w0", 8'h3C, 21, n);
            if (n == 29) check("s1_dr29", int'(bus.dataReady), 3);
            if (n == 30) begin
               check("s1_exec1", int'(bus.execute), 1);
               check("s1_txch1", int'(bus.tx_ch),   1);
            end
            lit_word("s1_w1", 8'hC3, 31, n);
            if (n == 40) begin
               check("s1_exec2", int'(bus.execute), 1);
               check("s1_txch2", int'(bus.tx_ch),   0);
            end
            lit_word("s1_w2", 8'h5A, 41, n);
         end
         2: begin
            if (n == 15 || n == 40) check("s2_err", int'(bus.err_overrun), 2);
            if (n == 19) check("s2_dr", int'(bus.dataReady), 2);
            if (n == 20) begin
               check("s2_exec", int'(bus.execute), 1);
               check("s2_txch", int'(bus.tx_ch),   1);
            end
            lit_word("s2", 8'h96, 21, n);
         end
         3: begin
            if (n == 23) check("s3_txv_pre", int'(bus.tx_valid), 1);
            if (n == 24) begin
               check("s3_dtx",   int'(bus.dataTx), 0);
               check("s3_ready", int'(bus.ready),  3);
            end
            if (n >= 24) begin
               check("s3_txv_after",  int'(bus.tx_valid), 0);
               check("s3_exec_after", int'(bus.execute),  0);
            end
         end
         default: begin
            if (n == 20) check("s4_ready0", int'(bus.ready[0]), 1);
            lit_word("s4_w0", 8'hA5, 21, n);
            if (n == 29) begin
               check("s4_exec29", int'(bus.execute),   0);
               check("s4_dr29",   int'(bus.dataReady), 1);
            end
            if (n == 30) begin
               check("s4_exec30", int'(bus.execute), 1);
               check("s4_txch",   int'(bus.tx_ch),   0);
            end
            lit_word("s4_w1", 8'h69, 31, n);
         end
      endcase
   endtask

   task automatic run_scn(int sid);
      rst       = 1'b1;
      bus.start = '0;
      bus.data  = '0;
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n <= 50; n++) begin
         drive(sid, n);
         lit(sid, n);
         @(negedge clk);
      end
   endtask

   initial begin
      bus.start = '0;
      bus.data  = '0;
      rst       = 1'b1;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      for (int s = 0; s < 5; s++) run_scn(s);
      rst = 1'b1;
      @(negedge clk);
      for (int c = 0; c < 4000; c++) begin
         rst       = ($urandom_range(0, 499) == 0);
         bus.start = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
         bus.data  = NC'($urandom);
         @(negedge clk);
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
